motoro3_pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator for the 3-phase motor drive, successor to the single-channel position-count PWM generator. Each channel converts a per-period on-time request into a PWM pulse. Requests below a programmable minimum are carried over as remainder rather than emitted, so no position ticks are lost. Each channel drives complementary high/low gate outputs with programmable dead time and keeps wanted-vs-real on-time statistics. The block sits between the commutation step sequencer (which supplies per-channel duty) and the MOSFET gate drivers.

---
 rtl/motoro3_pwm_multi_if.sv | 34 +++
 rtl/motoro3_pwm_multi.sv | 170 +++++++++++++++++
 tb/tb_motoro3_pwm_multi.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/motoro3_pwm_multi_if.sv
// Signal bundle between the commutation step sequencer (master) and the
// multi-channel PWM generator (slave). There is no valid/ready handshake
// here: every input is a level or single-cycle pulse that the slave samples
// on the falling clock edge, and every output is a registered level or
// single-cycle pulse that changes only on that falling edge (or at reset).
interface motoro3_pwm_multi_if #(
  parameter int NCH = 3,
  parameter int CW  = 12,
  parameter int AW  = 16,
  parameter int DTW = 4
) ();
  logic              enable;
  logic              syncStart;
  logic [CW-1:0]     periodLen;
  logic [CW-1:0]     minOn;
  logic [DTW-1:0]    deadTime;
  logic [NCH*AW-1:0] dutyIn;
  logic              statLatch;
  logic              periodStart;
  logic [NCH-1:0]    pwmH;
  logic [NCH-1:0]    pwmL;
  logic [NCH*AW-1:0] lost;
  logic              dbg_state;

  modport master (
    output enable, syncStart, periodLen, minOn, deadTime, dutyIn, statLatch,
    input  periodStart, pwmH, pwmL, lost, dbg_state
  );

  modport slave (
    input  enable, syncStart, periodLen, minOn, deadTime, dutyIn, statLatch,
    output periodStart, pwmH, pwmL, lost, dbg_state
  );
endinterface

// File: rtl/motoro3_pwm_multi.sv
// Multi-channel PWM generator for the 3-phase drive. A shared period counter
// produces period-start events; at each event every channel turns its duty
// request (plus carried remainder) into an on-time, drives complementary
// gate outputs with dead time, and tracks wanted vs. delivered on-cycles.
// All registers update on the falling clock edge.
module motoro3_pwm_multi #(
  parameter int NCH = 3,
  parameter int CW  = 12,
  parameter int AW  = 16,
  parameter int DTW = 4
) (
  input  logic                 clk,
  input  logic                 nRst,
  motoro3_pwm_multi_if.slave   bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW-1:0]  AMAX = '1;
  localparam logic [DTW-1:0] DMAX = '1;

  state_t         state_q, state_d;
  logic           ev;
  logic [CW-1:0]  per_eff;
  logic [CW-1:0]  cnt_q;
  logic           period_start_q;
  logic           running;

  logic [NCH-1:0]    h_all;
  logic [NCH-1:0]    l_all;
  logic [NCH*AW-1:0] lost_all;

  // Periods shorter than 2 cycles cannot hold a reload, so clamp them.
  assign per_eff = (bus.periodLen < CW'(2)) ? CW'(2) : bus.periodLen;
  assign running = (state_q == ST_RUN);

  // Next run state and the period-start event (restart, natural reload or sync).
  always_comb begin
    state_d = state_q;
    ev      = 1'b0;
    if (!bus.enable) begin
      state_d = ST_IDLE;
    end else begin
      state_d = ST_RUN;
      ev      = (state_q == ST_IDLE) || (cnt_q == CW'(1)) || bus.syncStart;
    end
  end

  // Run state, period down-counter and the period-start pulse.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      period_start_q <= ev;
      if (!bus.enable || ev) begin
        cnt_q <= per_eff;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [AW-1:0]  duty;
    logic [AW-1:0]  remain_q, remain_d;
    logic [AW-1:0]  want_q, real_q, lost_q;
    logic [CW-1:0]  on_q, on_d, on_len;
    logic [DTW-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic           h_q, h_d, l_q, l_d;
    logic           raw_q, raw_d;
    logic [AW:0]    sum_wide, want_wide;
    logic [AW-1:0]  sum, want_inc, want_sum, real_sum;

    assign duty  = bus.dutyIn[i*AW +: AW];
    assign raw_q = (on_q != '0);

    // On-time, remainder carry and dead-time run counters for the next cycle.
    always_comb begin
      sum_wide = {1'b0, remain_q} + {1'b0, duty};
      sum      = sum_wide[AW] ? AMAX : sum_wide[AW-1:0];
      on_len   = '0;
      remain_d = remain_q;
      on_d     = on_q;
      if (ev) begin
        if (sum >= AW'(bus.minOn)) begin
          // sum is no larger than per_eff on the else path, so it fits in CW.
          on_len   = (sum > AW'(per_eff)) ? per_eff : sum[CW-1:0];
          remain_d = sum - AW'(on_len);
        end else begin
          remain_d = sum;
        end
        on_d = on_len;
      end else if (on_q != '0) begin
        on_d = on_q - CW'(1);
      end
      raw_d = (on_d != '0);

      // Run lengths restart on every raw edge and on leaving idle.
      hcnt_d = '0;
      lcnt_d = '0;
      if (running && raw_q && raw_d) begin
        hcnt_d = (hcnt_q == DMAX) ? DMAX : hcnt_q + DTW'(1);
      end
      if (running && !raw_q && !raw_d) begin
        lcnt_d = (lcnt_q == DMAX) ? DMAX : lcnt_q + DTW'(1);
      end
      h_d = raw_d && (hcnt_d >= bus.deadTime);
      l_d = !raw_d && (lcnt_d >= bus.deadTime);

      // Statistics increments for this edge (duty at events, 1 per pwmH cycle).
      want_inc  = ev ? duty : '0;
      want_wide = {1'b0, want_q} + {1'b0, want_inc};
      want_sum  = want_wide[AW] ? AMAX : want_wide[AW-1:0];
      real_sum  = (h_q && (real_q != AMAX)) ? real_q + AW'(1) : real_q;
    end

    // Channel state; idle clears everything except the latched statistic.
    always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
        remain_q <= '0;
        on_q     <= '0;
        hcnt_q   <= '0;
        lcnt_q   <= '0;
        h_q      <= 1'b0;
        l_q      <= 1'b0;
        want_q   <= '0;
        real_q   <= '0;
        lost_q   <= '0;
      end else if (!bus.enable) begin
        remain_q <= '0;
        on_q     <= '0;
        hcnt_q   <= '0;
        lcnt_q   <= '0;
        h_q      <= 1'b0;
        l_q      <= 1'b0;
        want_q   <= '0;
        real_q   <= '0;
      end else begin
        remain_q <= remain_d;
        on_q     <= on_d;
        hcnt_q   <= hcnt_d;
        lcnt_q   <= lcnt_d;
        h_q      <= h_d;
        l_q      <= l_d;
        if (bus.statLatch) begin
          lost_q <= want_sum - real_sum;
          want_q <= want_inc;
          real_q <= {{(AW-1){1'b0}}, h_q};
        end else begin
          want_q <= want_sum;
          real_q <= real_sum;
        end
      end
    end

    assign h_all[i]            = h_q;
    assign l_all[i]            = l_q;
    assign lost_all[i*AW +: AW] = lost_q;
  end

  assign bus.periodStart = period_start_q;
  assign bus.pwmH        = h_all;
  assign bus.pwmL        = l_all;
  assign bus.lost        = lost_all;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_motoro3_pwm_multi.sv
// Bench for motoro3_pwm_multi: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a period-phase
// based behavioural model.
module tb_motoro3_pwm_multi;
  localparam int NCH = 3;
  localparam int CW  = 12;
  localparam int AW  = 16;
  localparam int DTW = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #50 clk = ~clk;

  motoro3_pwm_multi_if #(.NCH(NCH), .CW(CW), .AW(AW), .DTW(DTW)) bus ();
  motoro3_pwm_multi #(.NCH(NCH), .CW(CW), .AW(AW), .DTW(DTW)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase = cycles since the last period-start event; a channel is "raw on"
  // while phase < its on-length; dead time compares time since the last raw
  // level change against deadTime.
  bit          m_active;
  int          m_phase, m_per;
  int          m_on[NCH];
  int unsigned m_rem[NCH], m_want[NCH], m_real[NCH];
  logic [AW-1:0] m_lost[NCH];
  bit          m_raw[NCH];
  longint      m_t;
  longint      m_tchg[NCH];
  logic        m_ps;
  logic [NCH-1:0] m_h, m_l;
  bit          mev, nraw;
  int          meff;
  int unsigned md, ms, mw, mr, winc, rinc;

  task automatic model_clear(input bit full);
    m_active = 0; m_phase = 0; m_per = 2; m_ps = 0; m_h = '0; m_l = '0;
    for (int i = 0; i < NCH; i++) begin
      m_on[i] = 0; m_rem[i] = 0; m_want[i] = 0; m_real[i] = 0; m_raw[i] = 0;
      if (full) m_lost[i] = '0;
    end
  endtask

  initial model_clear(1);

  always @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      model_clear(1);
    end else if (!bus.enable) begin
      model_clear(0);
    end else begin
      m_t++;
      meff = (bus.periodLen < 2) ? 2 : int'(bus.periodLen);
      mev  = !m_active || (m_phase == m_per - 1) || bus.syncStart;
      if (mev) begin
        m_phase = 0;
        m_per   = meff;
      end else begin
        m_phase++;
      end
      for (int i = 0; i < NCH; i++) begin
        md   = bus.dutyIn[i*AW +: AW];
        winc = mev ? md : 0;
        rinc = m_h[i] ? 1 : 0;
        if (mev) begin
          ms = m_rem[i] + md;
          if (ms > 65535) ms = 65535;
          if (ms >= bus.minOn) begin
            m_on[i]  = (ms > meff) ? meff : int'(ms);
            m_rem[i] = ms - m_on[i];
          end else begin
            m_on[i]  = 0;
            m_rem[i] = ms;
          end
        end
        nraw = (m_phase < m_on[i]);
        if (!m_active || nraw != m_raw[i]) m_tchg[i] = m_t;
        m_raw[i] = nraw;
        m_h[i] = nraw && ((m_t - m_tchg[i]) >= bus.deadTime);
        m_l[i] = !nraw && ((m_t - m_tchg[i]) >= bus.deadTime);
        mw = m_want[i] + winc; if (mw > 65535) mw = 65535;
        mr = m_real[i] + rinc; if (mr > 65535) mr = 65535;
        if (bus.statLatch) begin
          m_lost[i] = AW'(mw - mr);
          m_want[i] = winc;
          m_real[i] = rinc;
        end else begin
          m_want[i] = mw;
          m_real[i] = mr;
        end
      end
      m_ps     = mev;
      m_active = 1;
    end
  end

  // ---------------- scoreboard compare (every cycle, mid-period of clk) ----------------
  logic [NCH*AW-1:0] exp_lost;
  always @(posedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NCH; i++) exp_lost[i*AW +: AW] = m_lost[i];
      check("periodStart", 64'(bus.periodStart), 64'(m_ps));
      check("pwmH", 64'(bus.pwmH), 64'(m_h));
      check("pwmL", 64'(bus.pwmL), 64'(m_l));
      check("lost", 64'(bus.lost), 64'(exp_lost));
      check("h_and_l_overlap", 64'(bus.pwmH & bus.pwmL), 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg(input int per, input int mo, input int dt);
    bus.periodLen = CW'(per);
    bus.minOn     = CW'(mo);
    bus.deadTime  = DTW'(dt);
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2);
    bus.dutyIn = {AW'(d2), AW'(d1), AW'(d0)};
  endtask

  task automatic go_idle();
    bus.enable = 1'b0;
    @(posedge clk);
  endtask

  task automatic window(input int n, input int ch, output int ps_n, output int ps_last,
                        output int h_n, output int l_n);
    ps_n = 0; ps_last = -1; h_n = 0; l_n = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (bus.periodStart) begin ps_n++; ps_last = i; end
      if (bus.pwmH[ch]) h_n++;
      if (bus.pwmL[ch]) l_n++;
    end
  endtask

  // ---------------- stimulus ----------------
  int ps_n, ps_last, h_n, l_n;

  initial begin
    bus.enable = 0; bus.syncStart = 0; bus.statLatch = 0;
    cfg(100, 20, 0);
    set_duty(0, 0, 0);
    repeat (3) @(posedge clk);
    check("reset_periodStart", 64'(bus.periodStart), 64'd0);
    check("reset_pwmH", 64'(bus.pwmH), 64'd0);
    check("reset_pwmL", 64'(bus.pwmL), 64'd0);
    check("reset_lost", 64'(bus.lost), 64'd0);
    check("reset_state", 64'(bus.dbg_state), 64'd0);
    cmp_en = 1;
    nRst   = 1;
    @(posedge clk);

    // Basic period / pulse width, deadTime 0.
    cfg(100, 20, 0); set_duty(30, 0, 0);
    bus.enable = 1;
    for (int p = 0; p < 2; p++) begin
      window(100, 0, ps_n, ps_last, h_n, l_n);
      check("t1_ps_count", 64'(ps_n), 64'd1);
      check("t1_ps_pos", 64'(ps_last), 64'd0);
      check("t1_h_width", 64'(h_n), 64'd30);
      check("t1_l_width", 64'(l_n), 64'd70);
    end

    // Sub-minimum requests carried over as remainder.
    go_idle();
    cfg(100, 20, 0); set_duty(8, 0, 0);
    bus.enable = 1;
    exp_q = {16'd0, 16'd0, 16'd24, 16'd0, 16'd0, 16'd24};
    while (exp_q.size() > 0) begin
      window(100, 0, ps_n, ps_last, h_n, l_n);
      check("t2_carry_width", 64'(h_n), 64'(exp_q.pop_front()));
    end

    // Minimal period with oversized duty: continuous raw, saturating remainder.
    go_idle();
    cfg(1, 0, 0); set_duty(0, 0, 16'h8000);
    bus.enable = 1;
    window(40, 2, ps_n, ps_last, h_n, l_n);
    check("t3_full_h", 64'(h_n), 64'd40);
    check("t3_full_ps", 64'(ps_n), 64'd20);
    bus.periodLen = 0;
    window(20, 2, ps_n, ps_last, h_n, l_n);
    check("t3_zero_per_h", 64'(h_n), 64'd20);

    // Dead time and lost-tick statistics.
    go_idle();
    cfg(100, 0, 5); set_duty(40, 0, 0);
    bus.enable = 1; bus.statLatch = 1;
    @(posedge clk);
    bus.statLatch = 0;
    window(100, 0, ps_n, ps_last, h_n, l_n);
    check("t4_dead_h", 64'(h_n), 64'd35);
    check("t4_dead_l", 64'(l_n), 64'd55);
    repeat (898) @(posedge clk);
    bus.statLatch = 1;
    @(posedge clk);
    bus.statLatch = 0;
    check("t4_lost0", 64'(bus.lost[AW-1:0]), 64'd50);

    // syncStart mid-period.
    go_idle();
    cfg(100, 0, 0); set_duty(0, 60, 0);
    bus.enable = 1;
    window(37, 1, ps_n, ps_last, h_n, l_n);
    check("t5_pre_h", 64'(h_n), 64'd37);
    check("t5_pre_ps", 64'(ps_n), 64'd1);
    bus.syncStart = 1;
    window(1, 1, ps_n, ps_last, h_n, l_n);
    bus.syncStart = 0;
    check("t5_sync_ps", 64'(ps_n), 64'd1);
    window(100, 1, ps_n, ps_last, h_n, l_n);
    check("t5_post_ps", 64'(ps_n), 64'd1);
    check("t5_post_ps_pos", 64'(ps_last), 64'd99);
    check("t5_post_h", 64'(h_n), 64'd60);

    // Asynchronous reset mid-pulse.
    window(5, 1, ps_n, ps_last, h_n, l_n);
    check("t6_pre_h", 64'(h_n), 64'd5);
    check("t6_pre_lost", 64'(bus.lost[AW-1:0]), 64'd50);
    #10 nRst = 0;
    #1;
    check("t6_rst_pwmH", 64'(bus.pwmH), 64'd0);
    check("t6_rst_pwmL", 64'(bus.pwmL), 64'd0);
    check("t6_rst_ps", 64'(bus.periodStart), 64'd0);
    check("t6_rst_lost", 64'(bus.lost), 64'd0);
    #20 nRst = 1;
    @(posedge clk);
    check("t6_first_ps", 64'(bus.periodStart), 64'd1);
    check("t6_first_h", 64'(bus.pwmH[1]), 64'd1);

    // Randomized operation against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      bus.periodLen = CW'($urandom_range(0, 40));
      bus.minOn     = CW'($urandom_range(0, 30));
      if ($urandom_range(0, 199) == 0) bus.deadTime = DTW'($urandom_range(0, 6));
      set_duty($urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 50));
      bus.syncStart = ($urandom_range(0, 49) == 0);
      bus.statLatch = ($urandom_range(0, 39) == 0);
      bus.enable    = ($urandom_range(0, 99) != 0);
    end
    bus.enable = 1; bus.syncStart = 0; bus.statLatch = 0;
    repeat (50) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
